// File: rtl/forecast_scheduler_pkg.sv
// Shared definitions for the forecast scheduler: FSM states, class codes,
// decision-tree thresholds and node indices.
package forecast_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EVAL = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    CLS_SUNNY = 3'b000,
    CLS_RAINY = 3'b001,
    CLS_SNOWY = 3'b110,
    CLS_ERROR = 3'b111
  } class_t;

  localparam int unsigned TH_TMAX_LO = 32'd17;
  localparam int unsigned TH_TMAX_HI = 32'd26;
  localparam int unsigned TH_PRECIP  = 32'd1;
  localparam int unsigned TH_TMIN    = 32'd1;

  localparam logic [2:0] NODE0 = 3'd0;
  localparam logic [2:0] NODE1 = 3'd1;
  localparam logic [2:0] NODE2 = 3'd2;
  localparam logic [2:0] NODE3 = 3'd3;
  localparam logic [2:0] NODE4 = 3'd4;

endpackage

// File: rtl/forecast_scheduler_tree_walker.sv
// One step of the forecast decision tree: given the current node and the
// latched features, report the next node or the leaf class reached.
module tree_walker
  import forecast_scheduler_pkg::*;
#(
  parameter int FEAT_W = 5
) (
  input  logic [FEAT_W-1:0] temp_max,
  input  logic [FEAT_W-1:0] temp_min,
  input  logic [FEAT_W-1:0] precip,
  input  logic [2:0]        node,
  output logic [2:0]        next_node,
  output logic              leaf,
  output class_t            cls
);

  localparam logic [FEAT_W-1:0] TMAX_LO = FEAT_W'(TH_TMAX_LO);
  localparam logic [FEAT_W-1:0] TMAX_HI = FEAT_W'(TH_TMAX_HI);
  localparam logic [FEAT_W-1:0] PRECIP  = FEAT_W'(TH_PRECIP);
  localparam logic [FEAT_W-1:0] TMIN    = FEAT_W'(TH_TMIN);

  // Node evaluation; any index outside the tree is a leaf with the error class.
  always_comb begin
    next_node = node;
    leaf      = 1'b0;
    cls       = CLS_ERROR;
    case (node)
      NODE0: begin
        if (temp_max <= TMAX_LO) next_node = NODE1;
        else                     next_node = NODE2;
      end
      NODE1: begin
        if (precip <= PRECIP) begin
          leaf = 1'b1;
          cls  = CLS_SUNNY;
        end else begin
          next_node = NODE3;
        end
      end
      NODE2: begin
        if (temp_max <= TMAX_HI) begin
          next_node = NODE4;
        end else begin
          leaf = 1'b1;
          cls  = CLS_SUNNY;
        end
      end
      NODE3: begin
        leaf = 1'b1;
        if (temp_min <= TMIN) cls = CLS_SNOWY;
        else                  cls = CLS_RAINY;
      end
      NODE4: begin
        leaf = 1'b1;
        if (precip <= PRECIP) cls = CLS_SUNNY;
        else                  cls = CLS_RAINY;
      end
      default: begin
        leaf = 1'b1;
        cls  = CLS_ERROR;
      end
    endcase
  end

endmodule

// File: rtl/forecast_scheduler.sv
// Round-robin front end that grants one weather station at a time to a shared
// decision-tree evaluator and holds the classified result until it is taken.
module forecast_scheduler
  import forecast_scheduler_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int FEAT_W = 5
) (
  input  logic                     CLOCK_50,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*FEAT_W-1:0]   req_temp_max,
  input  logic [NREQ*FEAT_W-1:0]   req_temp_min,
  input  logic [NREQ*FEAT_W-1:0]   req_precip,
  input  logic [NREQ*FEAT_W-1:0]   req_wind,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2:0]               rsp_class,
  output logic                     busy
);

  localparam int ID_W = $clog2(NREQ);

  state_t              state_r;
  logic [ID_W-1:0]     ptr_r;
  logic [FEAT_W-1:0]   tmax_r, tmin_r, precip_r, wind_r;
  logic [2:0]          node_r;
  logic                rsp_valid_r;
  logic [ID_W-1:0]     rsp_id_r;
  class_t              rsp_class_r;

  logic                found_s;
  logic [ID_W-1:0]     grant_id_s;
  logic [NREQ-1:0]     grant_s;
  logic [FEAT_W-1:0]   sel_tmax_s, sel_tmin_s, sel_precip_s, sel_wind_s;
  logic [2:0]          walk_next_s;
  logic                walk_leaf_s;
  class_t              walk_cls_s;
  logic                unused_wind_s;

  // Wind is captured with the request but plays no part in the class.
  assign unused_wind_s = ^wind_r;

  // Priority search: later writes win, so the lowest station at/after the pointer
  // beats any station below it, which only wins when nothing is at/after it.
  always_comb begin
    found_s    = 1'b0;
    grant_id_s = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (ID_W'(j) < ptr_r)) begin
        found_s    = 1'b1;
        grant_id_s = ID_W'(j);
      end else begin
        grant_id_s = grant_id_s;
      end
    end
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (ID_W'(j) >= ptr_r)) begin
        found_s    = 1'b1;
        grant_id_s = ID_W'(j);
      end else begin
        grant_id_s = grant_id_s;
      end
    end
  end

  // One-hot grant and feature mux for the winning station.
  always_comb begin
    grant_s      = '0;
    sel_tmax_s   = '0;
    sel_tmin_s   = '0;
    sel_precip_s = '0;
    sel_wind_s   = '0;
    if (found_s) grant_s[grant_id_s] = 1'b1;
    else         grant_s = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (ID_W'(j) == grant_id_s) begin
        sel_tmax_s   = req_temp_max[j*FEAT_W +: FEAT_W];
        sel_tmin_s   = req_temp_min[j*FEAT_W +: FEAT_W];
        sel_precip_s = req_precip[j*FEAT_W +: FEAT_W];
        sel_wind_s   = req_wind[j*FEAT_W +: FEAT_W];
      end else begin
        sel_tmax_s   = sel_tmax_s;
      end
    end
  end

  // Ready is only offered while idle and out of reset.
  always_comb begin
    if ((state_r == ST_IDLE) && !rst) req_ready = grant_s;
    else                               req_ready = '0;
  end

  tree_walker #(.FEAT_W(FEAT_W)) u_walker (
    .temp_max  (tmax_r),
    .temp_min  (tmin_r),
    .precip    (precip_r),
    .node      (node_r),
    .next_node (walk_next_s),
    .leaf      (walk_leaf_s),
    .cls       (walk_cls_s)
  );

  // Scheduler FSM with the response register.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      tmax_r      <= '0;
      tmin_r      <= '0;
      precip_r    <= '0;
      wind_r      <= '0;
      node_r      <= NODE0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_class_r <= CLS_SUNNY;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            tmax_r   <= sel_tmax_s;
            tmin_r   <= sel_tmin_s;
            precip_r <= sel_precip_s;
            wind_r   <= sel_wind_s;
            rsp_id_r <= grant_id_s;
            ptr_r    <= (grant_id_s == ID_W'(NREQ - 1)) ? '0 : grant_id_s + ID_W'(1);
            node_r   <= NODE0;
            state_r  <= ST_EVAL;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          if (walk_leaf_s) begin
            rsp_class_r <= walk_cls_s;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            node_r      <= walk_next_s;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_class = rsp_class_r;
  assign busy      = (state_r != ST_IDLE);

endmodule
